// File: rtl/dm_sized_access.sv
// ============================================================================
// dm_sized_access
// ----------------------------------------------------------------------------
// Byte-addressable data memory for the MEM stage. It supports byte, halfword
// and word loads and stores, is little-endian, and sign- or zero-extends loads.
// Misaligned or illegal requests never touch the array. They come back as an
// error response instead.
//
// Storage is four byte lanes. Each lane is 2**(ADDR_W-2) entries deep. Lane 0
// holds the least significant byte of each word. After reset, an init FSM can
// optionally zero the whole array, one word index per cycle. Requests are
// refused until that clear has finished.
//
// Ports
//   clk         single clock, all logic on its rising edge
//   rst_n       synchronous active-low reset
//   req_valid   request present
//   req_ready   block accepts a request this cycle (high only in RUN)
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  loads only: 1 sign-extend, 0 zero-extend
//   req_addr    byte address
//   req_wdata   store data (low 8/16 bits used for byte/half)
//   rsp_valid   one-cycle pulse, one cycle after each accepted request
//   rsp_rdata   extended load data; 0 for stores and errors
//   rsp_err     request was misaligned or illegal
//   init_done   clear finished; stays high until the next reset
// ============================================================================
module dm_sized_access #(
  parameter int ADDR_W       = 12,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int DEPTH  = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;

  // Picks the addressed byte or half out of a stored word and extends it to
  // the full data width. Word loads ignore sgn.
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        lane,
    input logic [1:0]        size,
    input logic              sgn
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- stage p0
  // Request decode and error check happen in the accept cycle.
  logic             acc_p0;
  logic             bad_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             clr_active;

  assign acc_p0 = req_valid & req_ready;
  assign idx_p0 = req_addr[ADDR_W-1:2];
  assign bad_p0 = (req_size == 2'b11)
                | ((req_size == SZ_HALF) & req_addr[0])
                | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

  // The clear shares the array write port. It never overlaps a request,
  // because req_ready stays low while the FSM is in INIT.
  assign clr_active = rst_n & (state == ST_INIT) & (CLEAR_ON_RST != 0);

  logic [3:0]        wr_be;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  // Store data is replicated across lanes so each lane can always take its
  // own byte slice. Only the byte enables select which lanes actually write.
  always_comb begin
    wr_be   = 4'b0000;
    wr_idx  = idx_p0;
    wr_data = req_wdata;
    if (clr_active) begin
      wr_be   = 4'b1111;
      wr_idx  = clr_cnt;
      wr_data = '0;
    end else if (acc_p0 && req_we && !bad_p0) begin
      case (req_size)
        SZ_BYTE: begin
          wr_be   = 4'b0001 << req_addr[1:0];
          wr_data = {4{req_wdata[7:0]}};
        end
        SZ_HALF: begin
          wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{req_wdata[15:0]}};
        end
        default: begin
          wr_be   = 4'b1111;
          wr_data = req_wdata;
        end
      endcase
    end
  end

  // Init / run control. RUN has no exit except reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if ((CLEAR_ON_RST == 0) || (clr_cnt == LAST_IDX)) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          state     <= ST_RUN;
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- stage p1
  // The array is read and written on the same edge. A store accepted in
  // cycle N is therefore already in the array when a load is accepted in
  // cycle N+1, so no forwarding path is needed.
  logic [7:0]        mem [4][DEPTH];
  logic [DATA_W-1:0] rd_word_p1;

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_be[l]) mem[l][wr_idx] <= wr_data[l*8 +: 8];
      if (acc_p0)   rd_word_p1[l*8 +: 8] <= mem[l][idx_p0];
    end
  end

  logic       vld_p1;
  logic       err_p1;
  logic       ld_p1;
  logic [1:0] lane_p1;
  logic [1:0] size_p1;
  logic       sgn_p1;

  // Control flops are reset, so a pending response is dropped by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      ld_p1  <= 1'b0;
    end else begin
      vld_p1 <= acc_p0;
      err_p1 <= acc_p0 & bad_p0;
      ld_p1  <= acc_p0 & ~req_we & ~bad_p0;
    end
  end

  // Lane select and extension controls travel with the read word.
  always_ff @(posedge clk) begin
    if (acc_p0) begin
      lane_p1 <= req_addr[1:0];
      size_p1 <= req_size;
      sgn_p1  <= req_signed;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_err   = err_p1;
  assign rsp_rdata = ld_p1 ? extend_load(rd_word_p1, lane_p1, size_p1, sgn_p1) : '0;

endmodule

// File: tb/tb_dm_sized_access.sv
// ============================================================================
// tb_dm_sized_access
// Scoreboard bench for dm_sized_access (ADDR_W=12, CLEAR_ON_RST=1). A byte
// array models the memory. The driver pushes expected responses and a
// negedge monitor pops them and compares them with the DUT output.
// ============================================================================
module tb_dm_sized_access;

  localparam int ADDR_W = 12;
  localparam int MEMSZ  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  dm_sized_access #(.ADDR_W(ADDR_W), .CLEAR_ON_RST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   op_id = 0;
  byte unsigned model_mem [MEMSZ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEMSZ; i++) model_mem[i] = 8'h00;
  endtask

  // Reference behaviour: a legal access covers 2**size consecutive bytes,
  // least significant byte at the lowest address.
  task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                              input int addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic err);
    int nbytes;
    logic [31:0] val;
    nbytes = 1 << size;
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && (addr % 4) != 0);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) model_mem[addr + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      end else begin
        val = 32'h0;
        for (int i = 0; i < nbytes; i++) val = val | (32'(model_mem[addr + i]) << (8 * i));
        if (sgn && nbytes < 4 && val[8 * nbytes - 1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
        rd = val;
      end
    end
  endtask

  // One request per call. Consecutive calls give back-to-back traffic.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input int addr, input logic [31:0] wdata);
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = ADDR_W'(addr);
    req_wdata  = wdata;
    @(posedge clk);
    model_access(we, size, sgn, addr, wdata, e.rdata, e.err);
    e.id = op_id++;
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts posedges after reset release until init_done is seen.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (!init_done && req_ready) begin
        tests++;
        fails++;
        $display("FAIL ready_before_init: req_ready=1 init_done=0 at cycle %0d", n);
      end
    end
  endtask

  // Monitor: every response must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: rdata=0x%08h err=%0b with nothing pending", rsp_rdata, rsp_err);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          fails++;
          $display("FAIL rsp_op%0d: got rdata=0x%08h err=%0b expected rdata=0x%08h err=%0b",
                   e.id, rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a;
    logic [1:0] sz;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    rst_n = 1'b1;
    wait_init(n);
    chk("init_cycles", 32'(n), 32'd1024);
    chk("ready_after_init", 32'(req_ready), 32'd1);
    model_clear();

    // Top word is zero after the clear.
    issue(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0);
    // Word store, then byte signed and half unsigned loads.
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'h8899AABB);
    issue(1'b0, 2'b00, 1'b1, 12'h011, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    // Byte store merges into the word.
    issue(1'b1, 2'b00, 1'b0, 12'h010, 32'h0000007F);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    // Error cases leave memory untouched.
    issue(1'b1, 2'b10, 1'b0, 12'h013, 32'hDEADBEEF);
    issue(1'b0, 2'b01, 1'b1, 12'h011, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 12'h000, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 12'h011, 32'hFFFF);
    issue(1'b0, 2'b10, 1'b1, 12'h010, 32'h0);
    idle(2);

    // Store then load on the very next cycle, then a bubble-free stream.
    issue(1'b1, 2'b01, 1'b0, 12'h020, 32'h00001234);
    issue(1'b0, 2'b01, 1'b1, 12'h020, 32'h0);
    for (int k = 0; k < 8; k++) begin
      issue(k[0], 2'(k % 3), k[1], 12'h020 + 4 * k, 32'hF0E0_8000 + 32'(k));
      chk("stream_valid", 32'(rsp_valid), 32'd1);
    end
    idle(2);

    // Randomised traffic over a small window so loads hit earlier stores.
    for (int k = 0; k < 400; k++) begin
      a  = int'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    // Store far-off patterns, including negative halves and bytes.
    issue(1'b1, 2'b10, 1'b0, 12'hFFC, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b1, 12'hFFE, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 12'hFFE, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 12'hFFE, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 12'hFFD, 32'h0);
    idle(3);
    chk("sb_empty_run", 32'(sb.size()), 32'd0);

    // Reset in the middle of the clear restarts it from index 0.
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hCAFEF00D);
    idle(3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) begin
      @(posedge clk);
      #1;
    end
    chk("mid_init_not_done", 32'(init_done), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit_cycles", 32'(n), 32'd1024);
    model_clear();
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 12'hFFC, 32'h0);
    idle(3);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
